// File: rtl/isa_pkg.sv
// isa_pkg
//   Shared definitions for the sequential ISA core.
//   - Opcode encodings OP_NOP .. OP_RD. Encodings 4'hD..4'hF are illegal.
//   - Instruction field offset helpers. Each helper takes ADDR_W as an argument.
//   - Opcode classification helpers: register write, flag update, illegal.
//   - Core FSM state enum.
//   Instruction layout: {op[3:0], rd, rs1, low[2*ADDR_W-1:0]}.
//   rs2 is the top ADDR_W bits of low. The immediate is the whole low field.
package isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_SLTU = 4'hB;
  localparam logic [3:0] OP_RD   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } isa_state_e;

  function automatic int isa_instr_w(input int addr_w);
    return 4 + 4 * addr_w;
  endfunction

  function automatic int isa_rd_lsb(input int addr_w);
    return 3 * addr_w;
  endfunction

  function automatic int isa_rs1_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int isa_low_w(input int addr_w);
    return 2 * addr_w;
  endfunction

  // Every legal opcode from ADD through SLTU writes rd.
  // LDI, MOV and MUL are included in that range.
  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SLTU);
  endfunction

  // LDI and MOV are data moves, so they leave the flags alone.
  // MUL and SLTU do update the flags.
  function automatic logic op_sets_flags(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_SRL)) || (op == OP_MUL) || (op == OP_SLTU);
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_RD;
  endfunction

endpackage

// File: rtl/isa_regfile.sv
// isa_regfile
//   NREGS x DATA_W register file for the sequential ISA core.
//   It has two combinational read ports and one synchronous write port.
//   Register 0 always reads as zero, and writes to it are dropped.
//   A synchronous reset clears every entry.
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   we/waddr/wdata  write port, committed on the rising edge
//   ra_addr/ra_data read port A (combinational)
//   rb_addr/rb_data read port B (combinational)
module isa_regfile
  import isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 is forced to zero on the read side as well.
  // This keeps the invariant independent of the write-side guard.
  assign ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];

endmodule

// File: rtl/isa_seq_core.sv
// isa_seq_core
//   Clocked ISA core. It accepts one instruction per valid/ready handshake.
//   It executes the instruction on a single-cycle ALU, or on a shift-add
//   multiplier that retires one bit per cycle.
//   It then writes back rd and presents the result on salida with a
//   one-cycle valid pulse.
//   Flow: IDLE -> EXEC -> (MUL x DATA_W) -> WB -> IDLE.
//   The core accepts nothing until WB has finished, so there are no hazards.
// Ports
//   clk, rst      clock; synchronous active-high reset
//   instruccion   {op, rd, rs1, low}; captured on accept
//   instr_valid   instruction present
//   instr_ready   high only in IDLE
//   salida        result of the last completed instruction (held)
//   salida_valid  one-cycle pulse in WB for legal opcodes
//   flag_z        zero flag, updated by ALU ops only
//   flag_c        ADD carry / SUB borrow, cleared by the other ALU ops
//   err           one-cycle pulse in WB for illegal opcodes
module isa_seq_core
  import isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  localparam int INSTR_W = isa_instr_w(ADDR_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruccion,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  salida,
  output logic               salida_valid,
  output logic               flag_z,
  output logic               flag_c,
  output logic               err
);

  localparam int RD_LSB  = isa_rd_lsb(ADDR_W);
  localparam int RS1_LSB = isa_rs1_lsb(ADDR_W);
  localparam int LOW_W   = isa_low_w(ADDR_W);
  localparam int SH_W    = $clog2(DATA_W);
  localparam int CNT_W   = $clog2(DATA_W + 1);

  isa_state_e         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  salida_q, salida_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd, rs1, rs2;
  logic [LOW_W-1:0]  imm;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic              rf_we;

  logic [DATA_W:0]   sum_ext, diff_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W-1:0] acc_next;

  assign op  = instr_q[INSTR_W-1 -: 4];
  assign rd  = instr_q[RD_LSB +: ADDR_W];
  assign rs1 = instr_q[RS1_LSB +: ADDR_W];
  assign imm = instr_q[LOW_W-1:0];
  assign rs2 = imm[LOW_W-1 -: ADDR_W];

  // salida_q already holds the final result while the core sits in WB.
  // The same value therefore serves as the write-back data.
  isa_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (salida_q),
    .ra_addr (rs1),
    .ra_data (rs1_val),
    .rb_addr (rs2),
    .rb_data (rs2_val)
  );

  // Single-cycle ALU. The carry and borrow come from one extra result bit.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum_ext   = {1'b0, rs1_val} + {1'b0, rs2_val};
    diff_ext  = {1'b0, rs1_val} - {1'b0, rs2_val};
    case (op)
      OP_ADD: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DATA_W-1:0];
        alu_carry = diff_ext[DATA_W];
      end
      OP_AND:  alu_res = rs1_val & rs2_val;
      OP_OR:   alu_res = rs1_val | rs2_val;
      OP_XOR:  alu_res = rs1_val ^ rs2_val;
      OP_SLL:  alu_res = rs1_val << rs2_val[SH_W-1:0];
      OP_SRL:  alu_res = rs1_val >> rs2_val[SH_W-1:0];
      OP_LDI:  alu_res = DATA_W'(imm);
      OP_MOV:  alu_res = rs1_val;
      OP_SLTU: alu_res = DATA_W'(rs1_val < rs2_val);
      OP_RD:   alu_res = rs1_val;
      default: alu_res = '0;
    endcase
  end

  // The final MUL iteration loads salida_q together with the WB transition.
  // That lets WB behave the same way for every opcode.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    salida_d = salida_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rf_we    = 1'b0;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instruccion;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op == OP_MUL) begin
          mcand_d  = rs1_val;
          mplier_d = rs2_val;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_MUL;
        end else begin
          state_d = ST_WB;
          if (op_is_illegal(op)) begin
            salida_d = '0;
            err_d    = 1'b1;
          end else begin
            salida_d = alu_res;
            valid_d  = 1'b1;
            if (op_sets_flags(op)) begin
              flag_z_d = (alu_res == '0);
              flag_c_d = alu_carry;
            end
          end
        end
      end

      ST_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d  = ST_WB;
          salida_d = acc_next;
          valid_d  = 1'b1;
          flag_z_d = (acc_next == '0);
          flag_c_d = 1'b0;
        end
      end

      ST_WB: begin
        rf_we   = op_writes_rd(op);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      salida_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      salida_q <= salida_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign salida       = salida_q;
  assign salida_valid = valid_q;
  assign err          = err_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;

endmodule

// File: tb/tb_isa_seq_core.sv
`timescale 1ns/1ps
// Self-checking bench for isa_seq_core (DATA_W=32, ADDR_W=4).
// Each accepted instruction is run through a behavioural ISA model.
// The model pushes the expected response and its due clock edge into a queue.
// A separate monitor pops that queue whenever the core pulses salida_valid or err.
module tb_isa_seq_core;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic [INSTR_W-1:0] instruccion;
  logic               instr_valid;
  logic               instr_ready;
  logic [DATA_W-1:0]  salida;
  logic               salida_valid;
  logic               flag_z;
  logic               flag_c;
  logic               err;

  isa_seq_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instruccion  (instruccion),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .salida       (salida),
    .salida_valid (salida_valid),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] sal;
    bit          z;
    bit          c;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          edge_cnt     = 0;
  bit          mon_en       = 1'b0;
  logic [31:0] m_regs [16];
  bit          m_z, m_c;
  logic [31:0] held_sal;
  bit          held_z, held_c;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ISA semantics are computed here with 64-bit arithmetic.
  // The response is due 2 edges after the accept edge, or 34 edges for MUL.
  task automatic modelIssue(input logic [19:0] ins, input int n_now);
    logic [3:0]  op  = ins[19:16];
    logic [3:0]  rd  = ins[15:12];
    logic [3:0]  rs1 = ins[11:8];
    logic [3:0]  rs2 = ins[7:4];
    logic [7:0]  imm = ins[7:0];
    logic [31:0] a   = m_regs[rs1];
    logic [31:0] b   = m_regs[rs2];
    longint      wide;
    logic [31:0] res = 32'h0;
    bit          carry = 1'b0;
    exp_t        e;
    case (op)
      4'h1: begin wide = longint'(a) + longint'(b); res = wide[31:0]; carry = (wide > 64'hFFFF_FFFF); end
      4'h2: begin res = a - b; carry = (a < b); end
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = a ^ b;
      4'h6: res = a << b[4:0];
      4'h7: res = a >> b[4:0];
      4'h8: res = {24'h0, imm};
      4'h9: res = a;
      4'hA: begin wide = longint'(a) * longint'(b); res = wide[31:0]; end
      4'hB: res = (a < b) ? 32'd1 : 32'd0;
      4'hC: res = a;
      default: res = 32'h0;
    endcase
    e.is_err = (op >= 4'hD);
    e.sal    = res;
    e.due    = n_now + 2 + ((op == 4'hA) ? 32 : 0);
    if ((op >= 4'h1 && op <= 4'h7) || op == 4'hA || op == 4'hB) begin
      m_z = (res == 32'h0);
      m_c = carry;
    end
    if (op >= 4'h1 && op <= 4'hB && rd != 4'h0) m_regs[rd] = res;
    e.z = m_z;
    e.c = m_c;
    sb_q.push_back(e);
  endtask

  // Wait for ready, scribbling junk on the bus while the core is busy.
  // Then present ins for exactly one accept edge.
  task automatic applyStimulus(input logic [19:0] ins);
    int waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 200) begin
      instr_valid = 1'($urandom_range(0, 1));
      instruccion = 20'($urandom);
      waited++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      checkOutput("ready_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    instr_valid = 1'b1;
    instruccion = ins;
    modelIssue(ins, edge_cnt);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruccion = 20'($urandom);
    @(negedge clk);
    checkOutput("ready_low_after_accept", 32'(instr_ready), 32'd0);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_z      = 1'b0;
    m_c      = 1'b0;
    held_sal = 32'h0;
    held_z   = 1'b0;
    held_c   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (salida_valid || err) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_output", {30'h0, err, salida_valid}, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("err", 32'(err), 32'(mon_e.is_err));
          checkOutput("salida_valid", 32'(salida_valid), 32'(!mon_e.is_err));
          checkOutput("latency_edge", 32'(edge_cnt), 32'(mon_e.due));
          checkOutput("salida", salida, mon_e.sal);
          checkOutput("flags_zc", {30'h0, flag_z, flag_c}, {30'h0, mon_e.z, mon_e.c});
          held_sal = mon_e.sal;
          held_z   = mon_e.z;
          held_c   = mon_e.c;
        end
      end else begin
        checkOutput("salida_hold", salida, held_sal);
        checkOutput("flags_hold", {30'h0, flag_z, flag_c}, {30'h0, held_z, held_c});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] r_op;
    logic [19:0] r_ins;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instruccion = '0;
    clearModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_salida", salida, 32'h0);
    checkOutput("reset_pulses", {30'h0, salida_valid, err}, 32'h0);
    checkOutput("reset_flags", {30'h0, flag_z, flag_c}, 32'h0);
    checkOutput("reset_ready", 32'(instr_ready), 32'd1);
    rst    = 1'b0;
    mon_en = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(20'h81087);
    applyStimulus(20'h12110);
    applyStimulus(20'hA3210);
    applyStimulus(20'h24010);
    applyStimulus(20'h80005);
    applyStimulus(20'hC0000);
    applyStimulus(20'hE0000);
    applyStimulus(20'hC0100);
    applyStimulus(20'h00000);
    applyStimulus(20'hB5140);
    applyStimulus(20'hB6410);

    $display("[TB] reset during MUL");
    applyStimulus(20'hA3210);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    clearModel();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("ready_after_reset", 32'(instr_ready), 32'd1);
    checkOutput("salida_after_reset", salida, 32'h0);
    applyStimulus(20'hC0100);

    $display("[TB] randomized sequence");
    for (int i = 0; i < 250; i++) begin
      r_op  = (i < 20 || $urandom_range(0, 3) == 0) ? 4'h8 : 4'($urandom_range(0, 15));
      r_ins = {r_op, 16'($urandom)};
      applyStimulus(r_ins);
    end

    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
